// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, visible flag, delayed active-low syncs, line/frame pulses and frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam logic [9:0] HL  = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VL  = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HV  = 10'(H_VISIBLE);
  localparam logic [9:0] HS0 = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VV  = 10'(V_VISIBLE);
  localparam logic [9:0] VS0 = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VISIBLE + V_FP + V_SYNC);
  logic [9:0] hc_n, vc_n;
  logic       top, hs_raw, vs_raw;
  // Flags are registered from the next counter values so they stay aligned with DrawX/DrawY.
  always_comb begin
    hc_n = DrawX == HL ? 10'd0 : DrawX + 10'd1;
    vc_n = DrawX != HL ? DrawY : DrawY == VL ? 10'd0 : DrawY + 10'd1;
    top  = hc_n == 10'd0 && vc_n == 10'd0;
  end
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= HL;
      DrawY       <= VL;
      blank       <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'hFF;
    end else begin
      DrawX       <= hc_n;
      DrawY       <= vc_n;
      blank       <= hc_n < HV && vc_n < VV;
      hs_raw      <= !(hc_n >= HS0 && hc_n < HS1);
      vs_raw      <= !(vc_n >= VS0 && vc_n < VS1);
      line_start  <= hc_n == 10'd0;
      frame_start <= top;
      frame_count <= top ? frame_count + 8'd1 : frame_count;
    end
  end
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hd, vd;
      always_ff @(posedge vga_clk) begin
        hd <= !reset_n ? '1 : SYNC_DELAY'({hd, hs_raw});
        vd <= !reset_n ? '1 : SYNC_DELAY'({vd, vs_raw});
      end
      assign hs = hd[SYNC_DELAY-1];
      assign vs = vd[SYNC_DELAY-1];
    end
  endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: arithmetic raster model checked every cycle, plus directed literal checks on four instances.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] xa, ya, xb, yb, xc, yc, xs, ys;
  logic       ba, ha, va, la, fa, bb, hb, vb, lb, fb;
  logic       bc, hc, vc, lc, fc, bs, hs_s, vs_s, ls_s, fs_s;
  logic [7:0] ca, cb, cc, cs;

  vga_timing_gen #(.SYNC_DELAY(1)) u_a (.vga_clk(clk), .reset_n(reset_n), .DrawX(xa), .DrawY(ya),
    .blank(ba), .hs(ha), .vs(va), .line_start(la), .frame_start(fa), .frame_count(ca));
  vga_timing_gen #(.SYNC_DELAY(0)) u_b (.vga_clk(clk), .reset_n(reset_n), .DrawX(xb), .DrawY(yb),
    .blank(bb), .hs(hb), .vs(vb), .line_start(lb), .frame_start(fb), .frame_count(cb));
  vga_timing_gen #(.SYNC_DELAY(3)) u_c (.vga_clk(clk), .reset_n(reset_n), .DrawX(xc), .DrawY(yc),
    .blank(bc), .hs(hc), .vs(vc), .line_start(lc), .frame_start(fc), .frame_count(cc));
  // Shrunken raster (15 x 8 = 120 clocks per frame) so whole-frame behaviour fits a short run.
  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_VISIBLE(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .SYNC_DELAY(1)) u_s (.vga_clk(clk), .reset_n(reset_n), .DrawX(xs), .DrawY(ys),
    .blank(bs), .hs(hs_s), .vs(vs_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(cs));

  longint t = -2;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) t <= !reset_n ? -1 : (t < -1 ? t : t + 1);

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Packed {DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count} for clock t after release.
  function automatic longint model(input longint t, input longint hv, input longint hf, input longint hsy,
                                   input longint hbp, input longint vv, input longint vf, input longint vsy,
                                   input longint vbp, input longint d);
    longint ht, vt, x, y, px, py, bl, h, v, c;
    ht = hv + hf + hsy + hbp;
    vt = vv + vf + vsy + vbp;
    if (t < 0) return ((ht - 1) << 23) | ((vt - 1) << 13) | (0 << 12) | (1 << 11) | (1 << 10) | 255;
    x = t % ht;
    y = (t / ht) % vt;
    bl = (x < hv && y < vv) ? 1 : 0;
    h = 1;
    v = 1;
    if (t >= d) begin
      px = (t - d) % ht;
      py = ((t - d) / ht) % vt;
      h = (px >= hv + hf && px < hv + hf + hsy) ? 0 : 1;
      v = (py >= vv + vf && py < vv + vf + vsy) ? 0 : 1;
    end
    c = (t / (ht * vt)) % 256;
    return (x << 23) | (y << 13) | (bl << 12) | (h << 11) | (v << 10)
         | ((x == 0 ? 1 : 0) << 9) | ((x == 0 && y == 0 ? 1 : 0) << 8) | c;
  endfunction

  function automatic longint pk(input logic [9:0] x, input logic [9:0] y, input logic b, input logic h,
                                input logic v, input logic l, input logic f, input logic [7:0] c);
    return longint'({x, y, b, h, v, l, f, c});
  endfunction

  always @(negedge clk) begin
    if (t > -2) begin
      chk("raster_d1", pk(xa, ya, ba, ha, va, la, fa, ca), model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1));
      chk("raster_d0", pk(xb, yb, bb, hb, vb, lb, fb, cb), model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0));
      chk("raster_d3", pk(xc, yc, bc, hc, vc, lc, fc, cc), model(t, 640, 16, 96, 48, 480, 10, 2, 33, 3));
      chk("raster_small", pk(xs, ys, bs, hs_s, vs_s, ls_s, fs_s, cs), model(t, 8, 2, 3, 2, 4, 1, 2, 1, 1));
    end
  end

  initial begin
    int bl_a = 0, hl_a = 0, hf_a = -1, hl_last = -1, hf_b = -1, hf_c = -1, ls_a = 0;
    int fs_k = 0, last_fs = -1, vl_s = 0, bl_s = 0, vf_x = -1, vf_y = -1, w = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", xa, 799);
    chk("rst_y", ya, 524);
    chk("rst_blank", ba, 0);
    chk("rst_hs", ha, 1);
    chk("rst_vs", va, 1);
    chk("rst_fc", ca, 255);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_x", xa, 0);
    chk("first_y", ya, 0);
    chk("first_blank", ba, 1);
    chk("first_ls", la, 1);
    chk("first_fs", fa, 1);
    chk("first_fc", ca, 0);
    for (int cyc = 0; cyc <= 30720; cyc++) begin
      if (cyc < 800) begin
        bl_a += int'(ba);
        if (!ha) begin
          if (hf_a < 0) hf_a = int'(xa);
          hl_a++;
          hl_last = cyc;
        end
        if (!hb && hf_b < 0) hf_b = int'(xb);
        if (!hc && hf_c < 0) hf_c = int'(xc);
      end
      if (cyc < 1600) ls_a += int'(la);
      if (cyc < 120) begin
        bl_s += int'(bs);
        if (!vs_s) begin
          vl_s++;
          if (vf_x < 0) begin
            vf_x = int'(xs);
            vf_y = int'(ys);
          end
        end
      end
      if (fs_s) begin
        chk("fc_seq", cs, fs_k % 256);
        if (last_fs >= 0) chk("fs_period", cyc - last_fs, 120);
        last_fs = cyc;
        fs_k++;
      end
      @(negedge clk);
    end
    chk("blank_per_line", bl_a, 640);
    chk("hs_low_count", hl_a, 96);
    chk("hs_first_d1", hf_a, 657);
    chk("hs_contiguous", hl_last - hf_a + 1, 96);
    chk("hs_first_d0", hf_b, 656);
    chk("hs_first_d3", hf_c, 659);
    chk("line_starts_2lines", ls_a, 2);
    chk("small_vs_low", vl_s, 30);
    chk("small_vs_first_x", vf_x, 1);
    chk("small_vs_first_y", vf_y, 5);
    chk("small_blank_frame", bl_s, 32);
    chk("frame_starts", fs_k, 257);
    chk("fc_wrapped", cs, 0);
    while (!(xs == 10'd11 && ys == 10'd5) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("wait_in_sync", (w < 200) ? 1 : 0, 1);
    chk("pre_rst_hs", hs_s, 0);
    chk("pre_rst_vs", vs_s, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", xs, 14);
    chk("mid_rst_y", ys, 7);
    chk("mid_rst_hs", hs_s, 1);
    chk("mid_rst_vs", vs_s, 1);
    chk("mid_rst_fc", cs, 255);
    chk("mid_rst_big_x", xa, 799);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_x", xs, 0);
    chk("restart_y", ys, 0);
    chk("restart_fs", fs_s, 1);
    chk("restart_fc", cs, 0);
    chk("restart_big_x", xa, 0);
    repeat (50) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that directly feeds the sprite/palette pixel stage. It produces DrawX/DrawY, the visible-region flag blank, and the hs/vs sync outputs for a 640x480@60 display.
- Sync outputs pass through a programmable delay so they line up with the downstream pipeline. The downstream stage has one clock of registered ROM/palette latency.
- Also provides frame_start/line_start pulses and a free-running frame counter for sprite animation.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, extra clocks applied to hs/vs only; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock (25 MHz); all logic on posedge
- reset_n  in  1  synchronous active-low reset
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 = (DrawX,DrawY) is inside the visible region; 0 = blanking
- hs  out  1  horizontal sync, active-low, delayed by SYNC_DELAY
- vs  out  1  vertical sync, active-low, delayed by SYNC_DELAY
- line_start  out  1  1 for the single cycle where DrawX==0
- frame_start  out  1  1 for the single cycle where DrawX==0 and DrawY==0
- frame_count  out  8  frame index; changes on the same edge frame_start rises

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Frame length = 420000 clocks at the defaults.
- Counters:
  - hc and vc are registers driven directly onto DrawX and DrawY.
  - Each clock: if hc==H_TOTAL-1 then hc<=0; otherwise hc<=hc+1.
  - vc advances only when hc wraps: if vc==V_TOTAL-1 then vc<=0; otherwise vc<=vc+1.
- Registered flags: blank, hs_raw, vs_raw, line_start and frame_start are computed from the next-state counter values. They are therefore always coincident with the DrawX/DrawY they describe, and there is no combinational path to the outputs.
- Flag definitions:
  - blank = (hc<H_VISIBLE) && (vc<V_VISIBLE).
  - hs_raw = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491); vs_raw is asserted for the whole line.
- Sync delay: hs and vs equal hs_raw and vs_raw passed through a SYNC_DELAY-deep shift register. With SYNC_DELAY=0 they equal hs_raw and vs_raw directly. Shift stages reset to 1.
- frame_count: reset value 8'hFF. It increments (mod 256) on the edge where frame_start becomes 1, so the first frame after reset is frame 0. 255 wraps to 0.
- Reset (reset_n==0 at posedge):
  - hc<=H_TOTAL-1, vc<=V_TOTAL-1. This gives DrawX=799 and DrawY=524.
  - blank<=0, line_start<=0, frame_start<=0.
  - hs_raw, vs_raw and all delay stages <=1, so hs=vs=1.
  - frame_count<=8'hFF.
- First edge after reset_n goes high: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0.
- Reset mid-frame: takes effect on the next posedge regardless of position, with the same values as above. No partial sync pulse may survive reset; the delay chain is forced to 1.
- Boundary behaviour:
  - DrawX==639 is the last pixel with blank=1 on a visible line; DrawX==640 has blank=0.
  - Lines 480..524 have blank=0 for every DrawX.
  - hc and vc never exceed H_TOTAL-1 and V_TOTAL-1.

Test Plan:
- Reset for 3 clocks, then release -> during reset DrawX=799, DrawY=524, blank=0, hs=vs=1, frame_count=255. First edge after release gives DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=0.
- Run 1 full line, SYNC_DELAY=1 -> blank=1 for exactly 640 clocks. hs=0 for exactly 96 consecutive clocks, first at DrawX=657. line_start pulses once per 800 clocks.
- Run 1 full frame -> frame_start period is exactly 420000 clocks. vs=0 for exactly 1600 clocks, starting 1 clock after DrawY reaches 490. blank is 0 throughout DrawY=480..524. There are 307200 blank=1 cycles per frame.
- Run 257 frame_starts -> frame_count sequence 0,1,...,255,0.
- Assert reset_n=0 at DrawX=700, DrawY=491 (inside both syncs) -> next edge gives hs=vs=1, DrawX=799, DrawY=524. After release, timing restarts at 0,0 with frame_count=0.
- Instantiate with SYNC_DELAY=0 and 3 -> hs falls at DrawX=656 and 659 respectively. DrawX, DrawY and blank are identical in both instances.
